// File: rtl/pll_reset_sequencer.sv
// Brings up a PLL and releases the core and peripheral resets in a fixed order
// once lock has been stable; any lock loss after core release restarts the PLL.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       periph_rst,
  output logic       ready,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  // Terminal values: each state lasts exactly N edges, so it ends when the counter holds N-1.
  localparam logic [CW-1:0] C_PLL_END    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_STABLE_END = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP_END    = CW'(STAGE_GAP_CYCLES - 1);

  localparam logic [2:0] S_PLL_RST    = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_REL_CORE   = 3'd3;
  localparam logic [2:0] S_REL_PERIPH = 3'd4;
  localparam logic [2:0] S_RUN        = 3'd5;

  logic          r_lock_meta;
  logic          r_lock_sync;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pll_rst;
  logic          r_core_rst;
  logic          r_periph_rst;
  logic          r_ready;
  logic [7:0]    r_lock_loss_count;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_lock_lost;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lock_lost = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_PLL_END) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_sync) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_lock_sync) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_END) begin
          w_state_nxt = S_REL_CORE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REL_CORE, S_REL_PERIPH: begin
        if (!r_lock_sync) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
          w_lock_lost = 1'b1;
        end else if (r_cnt == C_GAP_END) begin
          w_state_nxt = (r_state == S_REL_CORE) ? S_REL_PERIPH : S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!r_lock_sync) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
          w_lock_lost = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_meta       <= 1'b0;
      r_lock_sync       <= 1'b0;
      r_state           <= S_PLL_RST;
      r_cnt             <= '0;
      r_pll_rst         <= 1'b1;
      r_core_rst        <= 1'b1;
      r_periph_rst      <= 1'b1;
      r_ready           <= 1'b0;
      r_lock_loss_count <= 8'd0;
    end else begin
      r_lock_meta  <= locked;
      r_lock_sync  <= r_lock_meta;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      // Outputs decode the next state so they move on the same edge as the state.
      r_pll_rst    <= (w_state_nxt == S_PLL_RST);
      r_core_rst   <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_WAIT_LOCK) ||
                      (w_state_nxt == S_STABLE);
      r_periph_rst <= (w_state_nxt != S_REL_PERIPH) && (w_state_nxt != S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      if (w_lock_lost && (r_lock_loss_count != 8'hFF)) begin
        r_lock_loss_count <= r_lock_loss_count + 8'd1;
      end
    end
  end

  assign pll_rst         = r_pll_rst;
  assign core_rst        = r_core_rst;
  assign periph_rst      = r_periph_rst;
  assign ready           = r_ready;
  assign lock_loss_count = r_lock_loss_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues timestamped output
// vectors, a negedge monitor pops one entry whenever the output vector changes.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b1;
  logic       pll_rst;
  logic       core_rst;
  logic       periph_rst;
  logic       ready;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .STAGE_GAP_CYCLES   (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .locked         (locked),
    .pll_rst        (pll_rst),
    .core_rst       (core_rst),
    .periph_rst     (periph_rst),
    .ready          (ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  // Vector layout: {pll_rst, core_rst, periph_rst, ready, lock_loss_count}
  localparam logic [11:0] RESET_VEC = {4'b1110, 8'd0};

  typedef struct {
    int          stamp;
    logic [11:0] vec;
    string       name;
  } evt_t;

  evt_t        q[$];
  int          edge_n   = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mon_en   = 1'b0;
  logic [11:0] mon_prev;
  logic [11:0] exp_cur;
  logic [7:0]  exp_llc;
  logic [11:0] dut_vec;

  assign dut_vec = {pll_rst, core_rst, periph_rst, ready, lock_loss_count};

  always @(posedge refclk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
  endtask

  // Monitor: every change of the output vector must match the head of the queue.
  always @(negedge refclk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].stamp < edge_n) begin
        evt_t m;
        m = q.pop_front();
        n_checks++;
        $display("FAIL %s: missing change, expected %h after edge %0d, still %h at edge %0d",
                 m.name, m.vec, m.stamp, dut_vec, edge_n);
      end
      if (dut_vec !== mon_prev) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: got %h (was %h) at edge %0d, expected no change",
                   dut_vec, mon_prev, edge_n);
        end else begin
          evt_t e;
          e = q.pop_front();
          if (e.stamp == edge_n && dut_vec === e.vec) n_pass++;
          else $display("FAIL %s: got %h at edge %0d expected %h at edge %0d",
                        e.name, dut_vec, edge_n, e.vec, e.stamp);
        end
        mon_prev = dut_vec;
      end
    end
  end

  function automatic logic [11:0] mk(input logic p, input logic c, input logic pe, input logic r);
    return {p, c, pe, r, exp_llc};
  endfunction

  task automatic push_evt(input int stamp, input logic [11:0] vec, input string name);
    if (vec != exp_cur) begin
      q.push_back('{stamp: stamp, vec: vec, name: name});
      exp_cur = vec;
    end
  endtask

  task automatic at_edge(input int n);
    while (edge_n < n) @(negedge refclk);
  endtask

  // Release sequence measured from e0, the first edge spent in PLL_RST.
  task automatic push_seq(input int e0, input int core_off);
    push_evt(e0 + 3,            mk(1'b0, 1'b1, 1'b1, 1'b0), "pll_rst_fall");
    push_evt(e0 + core_off,     mk(1'b0, 1'b0, 1'b1, 1'b0), "core_rst_fall");
    push_evt(e0 + core_off + 2, mk(1'b0, 1'b0, 1'b0, 1'b0), "periph_rst_fall");
    push_evt(e0 + core_off + 4, mk(1'b0, 1'b0, 1'b0, 1'b1), "ready_rise");
  endtask

  task automatic do_reset(input int hold, input logic lk, output int e0);
    int r;
    r       = edge_n + 1;
    rst     = 1'b1;
    locked  = lk;
    exp_llc = 8'd0;
    push_evt(r, mk(1'b1, 1'b1, 1'b1, 1'b0), "rst_assert");
    at_edge(r + hold - 1);
    rst = 1'b0;
    e0  = r + hold;
  endtask

  // One-cycle lock drop sampled at edge g; FSM sees it at g+2 and replays from g+3.
  task automatic lose_lock(input int e0, output int e0n);
    int g;
    g       = e0 + 18;
    exp_llc = (exp_llc == 8'hFF) ? 8'hFF : exp_llc + 8'd1;
    push_evt(g + 2, mk(1'b1, 1'b1, 1'b1, 1'b0), "lock_loss");
    e0n = g + 3;
    push_seq(e0n, 12);
    at_edge(g - 1);
    locked = 1'b0;
    at_edge(g);
    locked = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    exp_llc = 8'd0;
    rst     = 1'b1;
    locked  = 1'b1;

    // Reset values, then plain bring-up with lock held high.
    at_edge(3);
    check("reset_values", dut_vec, RESET_VEC);
    exp_cur  = RESET_VEC;
    mon_prev = RESET_VEC;
    mon_en   = 1'b1;
    rst      = 1'b0;
    e0       = edge_n + 1;
    push_seq(e0, 12);

    // Lock lost in RUN: count goes to 1 and the sequence replays.
    lose_lock(e0, e0);

    // One-cycle rst pulse in RUN clears everything including the loss count.
    at_edge(e0 + 20);
    do_reset(1, 1'b1, e0);
    push_seq(e0, 12);

    // Glitch during STABLE restarts the stable window.
    at_edge(e0 + 20);
    do_reset(3, 1'b1, e0);
    push_seq(e0, 17);
    at_edge(e0 + 5);
    locked = 1'b0;
    at_edge(e0 + 6);
    locked = 1'b1;

    // No lock: pll_rst pulses every 36 cycles, nothing else moves.
    at_edge(e0 + 25);
    do_reset(3, 1'b0, e0);
    for (int k = 0; k < 3; k++) begin
      push_evt(e0 + 36 * k + 3,  mk(1'b0, 1'b1, 1'b1, 1'b0), "pll_rst_fall_nolock");
      push_evt(e0 + 36 * k + 35, mk(1'b1, 1'b1, 1'b1, 1'b0), "pll_rst_retry");
    end
    at_edge(e0 + 109);

    // 300 lock losses: counter saturates at 255.
    do_reset(2, 1'b1, e0);
    push_seq(e0, 12);
    for (int i = 0; i < 300; i++) begin
      lose_lock(e0, e0);
    end
    at_edge(e0 + 20);
    check("final_saturated", dut_vec, exp_cur);

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
